// File: rtl/dmem_pkg.sv
// Shared definitions for the CPU31 data-memory bridge: state encoding,
// error data value, latched request record and address translation.
package dmem_pkg;

  localparam logic [1:0]  S_IDLE = 2'd0;
  localparam logic [1:0]  S_REQ  = 2'd1;
  localparam logic [1:0]  S_WAIT = 2'd2;
  localparam logic [1:0]  S_DONE = 2'd3;

  localparam logic [31:0] DMEM_ERR_DATA = 32'h0;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_REQ  = S_REQ,
    ST_WAIT = S_WAIT,
    ST_DONE = S_DONE
  } state_e;

  // Request captured in IDLE; drives the bus for the whole transaction
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  // Wrap-around rebase of a CPU byte address onto the bus word address
  function automatic logic [31:0] xlate_addr(input logic [31:0] a,
                                             input logic [31:0] base);
    return (a - base) & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/dmem_bridge_if.sv
// CPU-side and bus-side signals of the data-memory bridge.
// slave: the bridge's view; master: the environment (CPU + bus) view.
interface dmem_bridge_if;
  logic        cpu_cs;
  logic        cpu_r;
  logic        cpu_w;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        cpu_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;

  modport slave (
    input  cpu_cs, cpu_r, cpu_w, cpu_addr, cpu_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    output cpu_rdata, cpu_stall, cpu_err,
    output mem_req_valid, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_cs, cpu_r, cpu_w, cpu_addr, cpu_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    input  cpu_rdata, cpu_stall, cpu_err,
    input  mem_req_valid, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_timeout_ctr.sv
// WAIT-phase cycle counter. Expires on the TIMEOUT-th enabled cycle after a
// clear, so the FSM spends exactly TIMEOUT cycles waiting before aborting.
module dmem_timeout_ctr #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

  logic [15:0] r_cnt;

  // Count enabled cycles; clear has priority
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      r_cnt <= '0;
    else if (i_clr)  r_cnt <= '0;
    else if (i_en)   r_cnt <= r_cnt + 16'd1;
  end

  assign o_expire = i_en && (r_cnt == LIMIT);

endmodule

// File: rtl/dmem_bridge.sv
// Bridges the single-cycle CPU31 data-memory port onto a valid/ready bus.
// The core is stalled while an access is outstanding; results (data, error)
// are presented for one DONE cycle, in which the CPU commits.
module dmem_bridge
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic          clk,
  input  logic          reset,
  dmem_bridge_if.slave  bus
);

  state_e      r_state, w_next;
  req_t        r_req;
  logic [31:0] r_rdata;
  logic        r_err;

  logic w_new, w_illegal, w_accept, w_reject;
  logic w_clr, w_en, w_expire, w_rsp;

  // Acceptance is gated by reset so every output is 0 while reset is held
  assign w_new     = reset && (r_state == ST_IDLE) && bus.cpu_cs && (bus.cpu_r || bus.cpu_w);
  assign w_illegal = (bus.cpu_r && bus.cpu_w) || (bus.cpu_addr[1:0] != 2'b00);
  assign w_accept  = w_new && !w_illegal;
  assign w_reject  = w_new &&  w_illegal;

  assign w_clr = (r_state == ST_REQ) && bus.mem_req_ready;
  assign w_en  = (r_state == ST_WAIT);
  assign w_rsp = w_en && bus.mem_rsp_valid;

  dmem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (w_clr),
    .i_en     (w_en),
    .o_expire (w_expire)
  );

  // Next-state decode; responses are only honoured in WAIT
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_new)                 w_next = w_illegal ? ST_DONE : ST_REQ;
      ST_REQ:  if (bus.mem_req_ready)     w_next = ST_WAIT;
      ST_WAIT: if (w_rsp || w_expire)     w_next = ST_DONE;
      default:                            w_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Latch the request once; CPU inputs are ignored for the rest of the access
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        r_req <= '0;
    else if (w_accept) r_req <= '{we:    bus.cpu_w,
                                  addr:  xlate_addr(bus.cpu_addr, BASE_ADDR),
                                  wdata: bus.cpu_wdata};
  end

  // Result capture: a response beats a simultaneous timeout
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_reject) begin
      r_rdata <= DMEM_ERR_DATA;
      r_err   <= 1'b1;
    end else if (w_rsp) begin
      r_rdata <= r_req.we ? DMEM_ERR_DATA : bus.mem_rsp_rdata;
      r_err   <= 1'b0;
    end else if (w_expire) begin
      r_rdata <= DMEM_ERR_DATA;
      r_err   <= 1'b1;
    end
  end

  // Output decode; bus payload is only driven while the request is offered
  assign bus.cpu_stall     = w_accept || (r_state == ST_REQ) || (r_state == ST_WAIT);
  assign bus.cpu_rdata     = (r_state == ST_DONE) ? r_rdata : 32'h0;
  assign bus.cpu_err       = (r_state == ST_DONE) && r_err;
  assign bus.mem_req_valid = (r_state == ST_REQ);
  assign bus.mem_we        = (r_state == ST_REQ) && r_req.we;
  assign bus.mem_addr      = (r_state == ST_REQ) ? r_req.addr  : 32'h0;
  assign bus.mem_wdata     = (r_state == ST_REQ) ? r_req.wdata : 32'h0;

endmodule

// File: tb/tb_dmem_bridge.sv
// Scoreboard bench for dmem_bridge: stimulus tasks push the expected DONE-cycle
// result, an independent monitor pops and compares on every release cycle.
module tb_dmem_bridge;

  logic clk = 1'b0;
  logic reset = 1'b0;

  dmem_bridge_if ifc();

  dmem_bridge #(.BASE_ADDR(32'h1001_0000), .TIMEOUT(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   hs_cnt = 0;
  int   exp_hs = 0;

  logic        post_cs = 1'b0, post_r = 1'b0, post_w = 1'b0;
  logic [31:0] post_addr = 32'h0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_post();
    ifc.cpu_cs    = post_cs;
    ifc.cpu_r     = post_r;
    ifc.cpu_w     = post_w;
    ifc.cpu_addr  = post_addr;
    ifc.cpu_wdata = 32'h0;
  endtask

  // Monitor: a release is stall falling, or an error pulse
  initial begin : mon
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) prev = 1'b0;
      else begin
        if ((prev && !ifc.cpu_stall) || ifc.cpu_err) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_release: err=%b rdata=%h, no response expected",
                     ifc.cpu_err, ifc.cpu_rdata);
          end else begin
            e = sb.pop_front();
            chk32({e.name, "_rdata"}, ifc.cpu_rdata, e.rdata);
            chk32({e.name, "_err"}, 32'(ifc.cpu_err), 32'(e.err));
          end
        end else begin
          chk32("rdata_zero_outside_done", ifc.cpu_rdata, 32'h0);
        end
        if (ifc.mem_req_valid && ifc.mem_req_ready) hs_cnt++;
        prev = ifc.cpu_stall;
      end
    end
  end

  // One CPU access with a scripted bus: ready after rdy_dly low REQ cycles,
  // response after rsp_dly empty WAIT cycles (never if !rsp_en)
  task automatic access(input string name, input logic r, input logic w,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input bit exp_req, input logic [31:0] exp_maddr,
                        input int rdy_dly, input int rsp_dly, input bit rsp_en,
                        input logic [31:0] rsp_data,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input int exp_stall);
    int stall_cnt, req_cyc, wait_cyc;
    bit done;
    stall_cnt = 0; req_cyc = 0; wait_cyc = 0; done = 0;
    sb.push_back('{exp_rdata, exp_err, name});
    if (exp_req) exp_hs++;
    @(posedge clk); #1;
    ifc.cpu_cs = 1'b1; ifc.cpu_r = r; ifc.cpu_w = w;
    ifc.cpu_addr = addr; ifc.cpu_wdata = wdata;
    ifc.mem_req_ready = 1'b0; ifc.mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk32({name, "_stall_idle"}, 32'(ifc.cpu_stall), 32'(exp_req));
    chk32({name, "_noreq_idle"}, 32'(ifc.mem_req_valid), 32'h0);
    if (!exp_req) begin
      @(posedge clk); #1;
      drive_post();
      @(negedge clk);
      chk32({name, "_nobus_done"}, 32'(ifc.mem_req_valid), 32'h0);
      chk32({name, "_nostall_done"}, 32'(ifc.cpu_stall), 32'h0);
      return;
    end
    stall_cnt = 1;
    for (int i = 0; i < 64 && !done; i++) begin
      @(posedge clk); #1;
      ifc.mem_req_ready = 1'b0; ifc.mem_rsp_valid = 1'b0; ifc.mem_rsp_rdata = 32'h0;
      if (!ifc.cpu_stall) begin
        done = 1;
        drive_post();
        chk32({name, "_stall_cycles"}, 32'(stall_cnt), 32'(exp_stall));
      end else begin
        stall_cnt++;
        ifc.cpu_addr  = 32'hFFFF_FFF0 ^ 32'(i << 4);
        ifc.cpu_wdata = ~wdata;
        if (ifc.mem_req_valid) begin
          chk32({name, "_mem_addr"}, ifc.mem_addr, exp_maddr);
          chk32({name, "_mem_we"}, 32'(ifc.mem_we), 32'(w));
          if (w) chk32({name, "_mem_wdata"}, ifc.mem_wdata, wdata);
          if (req_cyc == rdy_dly) begin
            ifc.mem_req_ready = 1'b1;
            ifc.mem_rsp_valid = 1'b1;          // must be ignored outside WAIT
            ifc.mem_rsp_rdata = 32'hBAD0_BAD0;
          end
          req_cyc++;
        end else begin
          if (rsp_en && wait_cyc == rsp_dly) begin
            ifc.mem_rsp_valid = 1'b1;
            ifc.mem_rsp_rdata = rsp_data;
          end
          wait_cyc++;
        end
      end
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL %s_release_timeout: stall never dropped, required %0d cycles", name, exp_stall);
    end
    @(negedge clk);
  endtask

  initial begin
    ifc.cpu_cs = 0; ifc.cpu_r = 0; ifc.cpu_w = 0;
    ifc.cpu_addr = 0; ifc.cpu_wdata = 0;
    ifc.mem_req_ready = 0; ifc.mem_rsp_valid = 0; ifc.mem_rsp_rdata = 0;

    @(negedge clk);
    chk32("rst_stall", 32'(ifc.cpu_stall), 32'h0);
    chk32("rst_err",   32'(ifc.cpu_err),   32'h0);
    chk32("rst_rdata", ifc.cpu_rdata,      32'h0);
    chk32("rst_valid", 32'(ifc.mem_req_valid), 32'h0);
    chk32("rst_addr",  ifc.mem_addr,       32'h0);
    @(posedge clk); #1; reset = 1'b1;

    // 1: basic read, minimum latency
    access("rd_basic", 1, 0, 32'h1001_0010, 32'h0, 1, 32'h0000_0010,
           0, 0, 1, 32'hCAFE_F00D, 32'hCAFE_F00D, 0, 3);
    // 2: write, ready held low 4 cycles, write returns 0
    access("wr_slow", 0, 1, 32'h1001_0004, 32'h1234_5678, 1, 32'h0000_0004,
           4, 0, 1, 32'h5555_AAAA, 32'h0, 0, 7);
    // 3: misaligned and r=w=1
    access("rd_misal", 1, 0, 32'h1001_0002, 32'h0, 0, 32'h0,
           0, 0, 0, 32'h0, 32'h0, 1, 0);
    access("rw_both", 1, 1, 32'h1001_0008, 32'h0, 0, 32'h0,
           0, 0, 0, 32'h0, 32'h0, 1, 0);
    // 4: timeout after 8 WAIT cycles, then a normal access
    access("rd_tmo", 1, 0, 32'h1001_0018, 32'h0, 1, 32'h0000_0018,
           0, 0, 0, 32'h0, 32'h0, 1, 10);
    access("rd_after_tmo", 1, 0, 32'h1001_0020, 32'h0, 1, 32'h0000_0020,
           0, 2, 1, 32'h0BAD_CAFE, 32'h0BAD_CAFE, 0, 5);
    // response on the last WAIT cycle beats the timeout
    access("rd_last_wait", 1, 0, 32'h1001_0024, 32'h0, 1, 32'h0000_0024,
           0, 7, 1, 32'h1357_9BDF, 32'h1357_9BDF, 0, 10);
    // address below base wraps
    access("rd_wrap", 1, 0, 32'h0000_0004, 32'h0, 1, 32'hEFFF_0004,
           1, 1, 1, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 0, 5);

    // 5: asynchronous reset during WAIT
    @(posedge clk); #1;
    ifc.cpu_cs = 1; ifc.cpu_r = 1; ifc.cpu_w = 0; ifc.cpu_addr = 32'h1001_0040;
    @(posedge clk); #1; ifc.mem_req_ready = 1; ifc.cpu_cs = 0; ifc.cpu_r = 0;
    @(posedge clk); #1; ifc.mem_req_ready = 0;
    exp_hs++;
    @(negedge clk);
    chk32("rst_wait_stall_before", 32'(ifc.cpu_stall), 32'h1);
    #1; reset = 1'b0; #1;
    chk32("arst_stall", 32'(ifc.cpu_stall), 32'h0);
    chk32("arst_valid", 32'(ifc.mem_req_valid), 32'h0);
    chk32("arst_err",   32'(ifc.cpu_err), 32'h0);
    chk32("arst_rdata", ifc.cpu_rdata, 32'h0);
    repeat (2) @(posedge clk);
    #1; reset = 1'b1;
    ifc.mem_rsp_valid = 1; ifc.mem_rsp_rdata = 32'h7777_7777;
    @(posedge clk); #1; ifc.mem_rsp_valid = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk32("late_rsp_stall", 32'(ifc.cpu_stall), 32'h0);
      chk32("late_rsp_valid", 32'(ifc.mem_req_valid), 32'h0);
      chk32("late_rsp_err",   32'(ifc.cpu_err), 32'h0);
    end
    access("rd_after_rst", 1, 0, 32'h1001_0044, 32'h0, 1, 32'h0000_0044,
           0, 0, 1, 32'h2468_ACE0, 32'h2468_ACE0, 0, 3);

    // 6: back-to-back reads, second request already present in DONE
    post_cs = 1; post_r = 1; post_w = 0; post_addr = 32'h1001_0030;
    access("b2b_first", 1, 0, 32'h1001_0028, 32'h0, 1, 32'h0000_0028,
           0, 0, 1, 32'h1111_2222, 32'h1111_2222, 0, 3);
    post_cs = 0; post_r = 0; post_addr = 32'h0;
    access("b2b_second", 1, 0, 32'h1001_0030, 32'h0, 1, 32'h0000_0030,
           0, 0, 1, 32'h3333_4444, 32'h3333_4444, 0, 3);

    repeat (3) @(negedge clk);
    chk32("bus_handshakes", 32'(hs_cnt), 32'(exp_hs));
    chk32("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
